// File: rtl/ili9341_pkg.sv
// Shared definitions for the ILI9341 frame sequencer.
//   state_t       : sequencer states
//   CMD_*         : ILI9341 command opcodes used for a full-frame write
//   addr_seq_byte : byte N (0..4) of a CASET/PASET command + address window
package ili9341_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CASET,
        PASET,
        RAMWR,
        PIX_HI,
        PIX_LO,
        DONE
    } state_t;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    // Window is always [0, last_addr]: opcode, start hi/lo (zero), end hi/lo.
    function automatic logic [7:0] addr_seq_byte(input logic [2:0] idx,
                                                 input logic [7:0] cmd,
                                                 input logic [15:0] last_addr);
        case (idx)
            3'd0:    return cmd;
            3'd1:    return 8'h00;
            3'd2:    return 8'h00;
            3'd3:    return last_addr[15:8];
            default: return last_addr[7:0];
        endcase
    endfunction

endpackage

// File: rtl/counter_2d.sv
// Two-dimensional raster counter.
//   clk, reset : rising-edge clock, synchronous active-high reset (to 0,0)
//   enable     : advance one position
//   x, y       : current position; x wraps at X_MODULUS-1 and carries into y
//   last       : position is (X_MODULUS-1, Y_MODULUS-1)
module counter_2d #(
    parameter int X_MODULUS = 4,
    parameter int Y_MODULUS = 2,
    parameter int XW        = $clog2(X_MODULUS) + 1,
    parameter int YW        = $clog2(Y_MODULUS) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);

    localparam logic [XW-1:0] X_LAST = XW'(X_MODULUS - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(Y_MODULUS - 1);

    assign last = (x == X_LAST) && (y == Y_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (enable) begin
            if (x == X_LAST) begin
                x <= '0;
                y <= (y == Y_LAST) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ili9341_frame_seq.sv
// ILI9341 full-frame write sequencer.
// On start (from IDLE) emits CASET + window, PASET + window, RAMWR, then
// WIDTH*HEIGHT RGB565 pixels as hi/lo bytes, over a valid/ready byte stream.
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   start               : request one frame (honoured in IDLE only)
//   busy, frame_done    : frame in progress / one-cycle completion pulse
//   tx_byte, tx_dc      : byte and D/CX (0 = command) offered to the SPI TX
//   tx_valid, tx_ready  : byte handshake
//   pix_x, pix_y        : pixel position being fetched
//   pix_data            : RGB565 for (pix_x, pix_y), combinational from source
import ili9341_pkg::*;

module ili9341_frame_seq #(
    parameter int WIDTH  = 240,
    parameter int HEIGHT = 320
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     frame_done,
    output logic [7:0]               tx_byte,
    output logic                     tx_dc,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic [$clog2(WIDTH):0]   pix_x,
    output logic [$clog2(HEIGHT):0]  pix_y,
    input  logic [15:0]              pix_data
);

    localparam logic [15:0] COL_LAST = 16'(WIDTH - 1);
    localparam logic [15:0] ROW_LAST = 16'(HEIGHT - 1);

    state_t     state, state_nxt;
    logic [2:0] idx, idx_nxt;     // byte index within CASET/PASET
    logic       hs;
    logic       pix_adv;
    logic       pix_last;
    logic       frame_end;

    assign hs        = tx_valid && tx_ready;
    assign pix_adv   = hs && (state == PIX_LO);
    assign frame_end = pix_adv && pix_last;

    // Clearing on the final pixel leaves the counter at (0,0) for the next
    // frame, so RAMWR needs no explicit counter clear.
    counter_2d #(
        .X_MODULUS (WIDTH),
        .Y_MODULUS (HEIGHT)
    ) u_cnt (
        .clk    (clk),
        .reset  (reset || frame_end),
        .enable (pix_adv),
        .x      (pix_x),
        .y      (pix_y),
        .last   (pix_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Outputs are decoded from state/idx, so they stay put while stalled;
    // pixel bytes are stable because pix_x/pix_y only move on a handshake.
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        busy       = 1'b0;
        frame_done = 1'b0;
        tx_valid   = 1'b0;
        tx_byte    = 8'h00;
        tx_dc      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CASET;
                    idx_nxt   = '0;
                end
            end
            CASET, PASET: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_byte  = (state == CASET) ? addr_seq_byte(idx, CMD_CASET, COL_LAST)
                                            : addr_seq_byte(idx, CMD_PASET, ROW_LAST);
                tx_dc    = (idx != 3'd0);
                if (hs) begin
                    if (idx == 3'd4) begin
                        idx_nxt   = '0;
                        state_nxt = (state == CASET) ? PASET : RAMWR;
                    end else begin
                        idx_nxt = idx + 3'd1;
                    end
                end
            end
            RAMWR: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_byte  = CMD_RAMWR;
                if (hs) state_nxt = PIX_HI;
            end
            PIX_HI: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_byte  = pix_data[15:8];
                tx_dc    = 1'b1;
                if (hs) state_nxt = PIX_LO;
            end
            PIX_LO: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_byte  = pix_data[7:0];
                tx_dc    = 1'b1;
                if (hs) state_nxt = pix_last ? DONE : PIX_HI;
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ili9341_frame_seq.sv
// Randomized self-checking bench for ili9341_frame_seq (4x2 frame plus a
// default-size instance for the address window bytes).
module tb_ili9341_frame_seq;

    localparam int W = 4;
    localparam int H = 2;

    logic        clk = 1'b0;
    logic        reset, start, tx_ready;
    logic        busy, frame_done, tx_dc, tx_valid;
    logic [7:0]  tx_byte;
    logic [$clog2(W):0] pix_x;
    logic [$clog2(H):0] pix_y;
    logic [15:0] pix_data;
    logic [15:0] salt;

    logic        d_reset, d_start;
    logic        d_busy, d_frame_done, d_tx_dc, d_tx_valid;
    logic [7:0]  d_tx_byte;
    logic [8:0]  d_pix_x;
    logic [9:0]  d_pix_y;

    always #5 clk = ~clk;

    // Pixel source: {row, col} per byte, optionally scrambled by salt.
    assign pix_data = {8'(pix_y), 8'(pix_x)} ^ salt;

    ili9341_frame_seq #(.WIDTH(W), .HEIGHT(H)) u_dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .frame_done(frame_done), .tx_byte(tx_byte), .tx_dc(tx_dc),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .pix_x(pix_x),
        .pix_y(pix_y), .pix_data(pix_data)
    );

    ili9341_frame_seq u_dut_def (
        .clk(clk), .reset(d_reset), .start(d_start), .busy(d_busy),
        .frame_done(d_frame_done), .tx_byte(d_tx_byte), .tx_dc(d_tx_dc),
        .tx_valid(d_tx_valid), .tx_ready(1'b1), .pix_x(d_pix_x),
        .pix_y(d_pix_y), .pix_data(16'h0000)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model: the whole frame as a list of {dc, byte}.
    logic [8:0] exp_q[$];

    task automatic build_frame(input logic [15:0] s);
        logic [15:0] v;
        exp_q.delete();
        exp_q.push_back({1'b0, 8'h2A});
        exp_q.push_back({1'b1, 8'h00});
        exp_q.push_back({1'b1, 8'h00});
        exp_q.push_back({1'b1, 8'((W - 1) / 256)});
        exp_q.push_back({1'b1, 8'((W - 1) % 256)});
        exp_q.push_back({1'b0, 8'h2B});
        exp_q.push_back({1'b1, 8'h00});
        exp_q.push_back({1'b1, 8'h00});
        exp_q.push_back({1'b1, 8'((H - 1) / 256)});
        exp_q.push_back({1'b1, 8'((H - 1) % 256)});
        exp_q.push_back({1'b0, 8'h2C});
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                v = {8'(y), 8'(x)} ^ s;
                exp_q.push_back({1'b1, v[15:8]});
                exp_q.push_back({1'b1, v[7:0]});
            end
    endtask

    // Monitor: handshake stream, stall stability, frame_done timing.
    int         cyc = 0;
    int         hs_cnt = 0;
    int         last_hs = -10;
    int         done_cnt = 0;
    logic       hold_pending = 1'b0;
    logic [8:0] held;

    always @(negedge clk) begin
        logic [8:0] e;
        cyc++;
        if (reset) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                chk("stall_valid", tx_valid, 1'b1);
                chk("stall_hold", {tx_dc, tx_byte}, held);
            end
            hold_pending = tx_valid && !tx_ready;
            held = {tx_dc, tx_byte};
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_byte", {tx_dc, tx_byte}, 9'h1FF);
                end else begin
                    e = exp_q.pop_front();
                    chk("stream_byte", {tx_dc, tx_byte}, e);
                end
                hs_cnt++;
                last_hs = cyc;
            end
            if (frame_done) begin
                done_cnt++;
                chk("done_latency", cyc, last_hs + 1);
                chk("done_hs_count", hs_cnt, 11 + 2 * W * H);
            end
        end
    end

    task automatic start_pulse();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int bound);
        int n = 0;
        while (done_cnt < target && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", 32'(done_cnt >= target), 1);
    endtask

    initial begin
        logic [8:0] dexp[11];
        bit finished;
        reset = 1'b1; start = 1'b0; tx_ready = 1'b1; salt = 16'h0;
        d_reset = 1'b1; d_start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", {busy, frame_done, tx_valid, tx_dc, tx_byte}, 12'h000);
        chk("rst_pix", {pix_y, pix_x}, 0);
        @(posedge clk); #1 reset = 1'b0; d_reset = 1'b0;

        // Frame A: always ready, plain {y,x} pixels.
        build_frame(16'h0);
        hs_cnt = 0;
        start_pulse();
        @(negedge clk);
        chk("start_busy_valid", {busy, tx_valid}, 2'b11);
        wait_done(1, 500);
        repeat (3) @(negedge clk);
        chk("frameA_done_cnt", done_cnt, 1);
        chk("frameA_queue_empty", exp_q.size(), 0);
        chk("frameA_idle", {busy, tx_valid}, 2'b00);

        // Frame B: random ready, random pixels, stray starts while busy and in DONE.
        salt = 16'($urandom);
        build_frame(salt);
        hs_cnt = 0;
        start_pulse();
        finished = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (done_cnt >= 2) begin
                start = 1'b0;
                finished = 1'b1;
                break;
            end
            tx_ready = 1'($urandom % 2);
            if (frame_done)  start = 1'b1;
            else if (busy)   start = ($urandom % 4) == 0;
            else             start = 1'b0;
        end
        start = 1'b0;
        tx_ready = 1'b1;
        chk("frameB_finished", finished, 1'b1);
        repeat (5) @(negedge clk);
        chk("frameB_done_cnt", done_cnt, 2);
        chk("frameB_queue_empty", exp_q.size(), 0);
        chk("frameB_idle", {busy, tx_valid}, 2'b00);

        // Frame C: reset after the 8th pixel byte, then a clean frame.
        salt = 16'($urandom);
        build_frame(salt);
        hs_cnt = 0;
        start_pulse();
        for (int i = 0; i < 200 && hs_cnt < 19; i++) begin
            @(posedge clk); #1;
        end
        chk("reset_point_reached", hs_cnt, 19);
        chk("pix_mid", {pix_y, pix_x}, {2'(4 / W), 3'(4 % W)});
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_outputs", {busy, frame_done, tx_valid}, 3'b000);
        chk("midrst_pix", {pix_y, pix_x}, 0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_no_done", done_cnt, 2);
        chk("midrst_idle", tx_valid, 1'b0);
        salt = 16'($urandom);
        build_frame(salt);
        hs_cnt = 0;
        start_pulse();
        @(negedge clk);
        chk("restart_first", {tx_dc, tx_byte}, 9'h02A);
        wait_done(3, 500);
        repeat (2) @(negedge clk);
        chk("frameC_done_cnt", done_cnt, 3);
        chk("frameC_queue_empty", exp_q.size(), 0);

        // Default 240x320 instance: header bytes only.
        dexp = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h1EF,
                 9'h02B, 9'h100, 9'h100, 9'h101, 9'h13F, 9'h02C};
        @(posedge clk); #1 d_start = 1'b1;
        @(posedge clk); #1 d_start = 1'b0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            chk("def_valid", d_tx_valid, 1'b1);
            chk("def_header", {d_tx_dc, d_tx_byte}, dexp[i]);
        end
        @(negedge clk);
        chk("def_first_pixel", {d_tx_dc, d_tx_byte, d_pix_y, d_pix_x}, {9'h100, 10'd0, 9'd0});
        @(posedge clk); #1 d_reset = 1'b1;
        @(posedge clk); #1 d_reset = 1'b0;
        @(negedge clk);
        chk("def_reset", {d_busy, d_frame_done, d_tx_valid}, 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ili9341_frame_seq.md
ILI9341_FRAME_SEQ -- requirements
Module: ili9341_frame_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 240, display columns per frame.
REQ-002 SHALL have parameter HEIGHT, default 320, display rows per frame.
REQ-003 SHALL have port clk, input, 1, clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port start, input, 1, request to send one full frame.
REQ-006 SHALL have port busy, output, 1, high while a frame is in progress.
REQ-007 SHALL have port frame_done, output, 1, single-cycle pulse on completion.
REQ-008 SHALL have port tx_byte, output, 8, byte offered to the SPI byte transmitter.
REQ-009 SHALL have port tx_dc, output, 1, D/CX for tx_byte; 0 = command, 1 = data.
REQ-010 SHALL have port tx_valid, output, 1, tx_byte/tx_dc are valid.
REQ-011 SHALL have port tx_ready, input, 1, transmitter accepts the byte this cycle.
REQ-012 SHALL have port pix_x, output, $clog2(WIDTH)+1, current pixel column.
REQ-013 SHALL have port pix_y, output, $clog2(HEIGHT)+1, current pixel row.
REQ-014 SHALL have port pix_data, input, 16, RGB565 for (pix_x, pix_y); combinational from the source, sampled at use.

Function
REQ-015 SHALL transfer a byte only on a cycle with tx_valid && tx_ready (the handshake).
REQ-016 SHALL hold tx_byte and tx_dc stable, with tx_valid high, until the handshake occurs.
REQ-017 SHALL use states IDLE, CASET, PASET, RAMWR, PIX_HI, PIX_LO, DONE.
REQ-018 SHALL accept start only in IDLE: busy high and tx_valid high from the next cycle, state CASET; start is ignored elsewhere.
REQ-019 In CASET, SHALL send 0x2A (dc=0), then data bytes 0x00, 0x00, (WIDTH-1)>>8, (WIDTH-1)&0xFF (dc=1); after the 5th handshake go to PASET.
REQ-020 In PASET, SHALL send 0x2B (dc=0), then 0x00, 0x00, (HEIGHT-1)>>8, (HEIGHT-1)&0xFF (dc=1); then go to RAMWR.
REQ-021 In RAMWR, SHALL send 0x2C (dc=0); then go to PIX_HI with pix_x = pix_y = 0.
REQ-022 In PIX_HI, SHALL send pix_data[15:8] (dc=1); in PIX_LO, SHALL send pix_data[7:0] (dc=1).
REQ-023 SHALL advance the pixel counter only on the PIX_LO handshake: x increments, wraps at WIDTH-1 to 0 and increments y.
REQ-024 On the PIX_LO handshake at (WIDTH-1, HEIGHT-1), SHALL enter DONE, deassert tx_valid and return the counter to (0,0).
REQ-025 In DONE, SHALL pulse frame_done for exactly one cycle, drop busy, and go to IDLE; start in that cycle is ignored.
REQ-026 SHALL keep pix_x and pix_y constant except on the PIX_LO handshake or reset.
REQ-027 tx_valid SHALL be high in every state except IDLE and DONE; tx_ready is ignored when tx_valid is low.
REQ-028 A frame SHALL comprise exactly 11 + 2*WIDTH*HEIGHT handshakes.

Reset
REQ-029 While reset is high, SHALL enter IDLE with busy=0, frame_done=0, tx_valid=0, tx_byte=0x00, tx_dc=0, pix_x=0, pix_y=0.
REQ-030 Reset mid-frame SHALL abandon the frame without a frame_done pulse; the next start SHALL restart from CASET.

Structure
REQ-031 SHALL place the command opcodes (0x2A, 0x2B, 0x2C) and the state enumeration in the shared package ili9341_pkg.
REQ-032 SHALL instantiate counter_2d (X_MODULUS=WIDTH, Y_MODULUS=HEIGHT) as its only sub-module, with enable = PIX_LO handshake and reset = reset OR the final handshake.

Verification
REQ-033 WIDTH=4, HEIGHT=2, tx_ready tied 1, start pulse -> bytes 2A,00,00,00,03,2B,00,00,00,01,2C, then 16 pixel bytes; frame_done 1 cycle after the 27th handshake.
REQ-034 tx_ready toggling pseudo-randomly -> identical byte sequence; tx_byte/tx_dc never change while tx_valid=1 and tx_ready=0.
REQ-035 pix_data = {pix_y, pix_x} zero-extended -> pixel byte pairs 0000,0001,0002,0003,0100,...,0103 in order.
REQ-036 start reasserted while busy and in the DONE cycle -> ignored; exactly one frame_done per accepted start.
REQ-037 reset asserted after the 8th pixel handshake -> next cycle tx_valid=0, pix_x=pix_y=0, no frame_done; new start -> sequence begins at 0x2A.
REQ-038 Defaults 240x320 -> CASET data 00,00,00,EF; PASET data 00,00,01,3F; 153611 handshakes per frame.
